// File: rtl/dcache_responder_if.sv
// dcache_responder_if: pipeline-side request/response and line-burst memory signals of the data cache.
interface dcache_responder_if;
    logic         dcache_read;
    logic         dcache_write;
    logic [31:0]  dcache_addr;
    logic [3:0]   dcache_byte_enable;
    logic [31:0]  dcache_wdata;
    logic [31:0]  dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  dcache_read, dcache_write, dcache_addr, dcache_byte_enable, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output dcache_read, dcache_write, dcache_addr, dcache_byte_enable, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-back write-allocate data cache with a 256-bit line burst port.
// Defining DCACHE_PERF_CNT_EN adds the perf_hits/perf_misses counter outputs.
module dcache_responder #(
    parameter int NUM_SETS = 16
) (
    input  logic clk,
    input  logic rst,
    dcache_responder_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t             r_state, w_next;
    logic [NUM_SETS-1:0] r_valid, r_dirty;
    logic [TAG_W-1:0]   r_tag [NUM_SETS];
    logic [255:0]       r_data [NUM_SETS];
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [7:0]         w_off;
    logic [255:0]       w_line;
    logic [31:0]        w_mask, w_merged;
    logic               w_req, w_hit, w_wr_hit, w_wb_done, w_fill_done, w_unused;

    assign w_idx       = bus.dcache_addr[4+IDX_W:5];
    assign w_tag       = bus.dcache_addr[31:5+IDX_W];
    assign w_off       = {bus.dcache_addr[4:2], 5'b0};
    assign w_line      = r_data[w_idx];
    assign w_req       = bus.dcache_read | bus.dcache_write;
    assign w_hit       = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign w_wr_hit    = r_state == IDLE && bus.dcache_write && w_hit;
    assign w_wb_done   = r_state == WRITEBACK && bus.pmem_resp;
    assign w_fill_done = r_state == FILL && bus.pmem_resp;
    assign w_mask      = {{8{bus.dcache_byte_enable[3]}}, {8{bus.dcache_byte_enable[2]}},
                          {8{bus.dcache_byte_enable[1]}}, {8{bus.dcache_byte_enable[0]}}};
    assign w_merged    = (w_line[w_off +: 32] & ~w_mask) | (bus.dcache_wdata & w_mask);
    assign w_unused    = &{1'b0, bus.dcache_addr[1:0]};

    always_comb begin
        w_next           = r_state;
        bus.dcache_resp  = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_addr    = {w_tag, w_idx, 5'b0};
        bus.pmem_wdata   = w_line;
        bus.dcache_rdata = w_line[w_off +: 32];
        case (r_state)
            IDLE: begin
                bus.dcache_resp = w_req && w_hit;
                if (w_req && !w_hit) w_next = r_dirty[w_idx] ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.pmem_addr  = {r_tag[w_idx], w_idx, 5'b0};
                if (bus.pmem_resp) w_next = FILL;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (w_fill_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_wb_done) r_dirty[w_idx] <= 1'b0;
            else if (w_wr_hit && |bus.dcache_byte_enable) r_dirty[w_idx] <= 1'b1;
        end
    end

    // Line storage carries no reset; valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_idx] <= bus.pmem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) r_data[w_idx][w_off +: 32] <= w_merged;
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else if (r_state == IDLE && w_req) begin
            perf_hits   <= perf_hits + {31'b0, w_hit};
            perf_misses <= perf_misses + {31'b0, !w_hit};
        end
    end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder: random and directed accesses scored against a flat-memory plus residency model.
module tb_dcache_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_responder_if bus();
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] perf_hits, perf_misses;
    dcache_responder #(.NUM_SETS(16)) dut (.clk(clk), .rst(rst), .bus(bus), .perf_hits(perf_hits), .perf_misses(perf_misses));
`else
    dcache_responder #(.NUM_SETS(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {bit rd; logic [31:0] data;} exp_t;
    typedef struct {bit wr; logic [31:0] addr; logic [255:0] wdata; int lat;} txn_t;

    exp_t         sb[$];
    txn_t         log_q[$];
    logic [255:0] pm_lines [logic [26:0]];
    logic [255:0] ref_lines [logic [26:0]];
    logic [26:0]  s_la [16];
    bit           s_valid [16];
    bit           s_dirty [16];
    int           m_hits, m_misses, fixed_lat, checks, errors;

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [26:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {la, 3'(i), 2'b00} ^ 32'hC3A5_5A3C;
        return l;
    endfunction

    function automatic logic [255:0] pm_get(input logic [26:0] la);
        return pm_lines.exists(la) ? pm_lines[la] : init_line(la);
    endfunction

    function automatic logic [255:0] ref_get(input logic [26:0] la);
        return ref_lines.exists(la) ? ref_lines[la] : init_line(la);
    endfunction

    // Backing memory: random or fixed latency, one-cycle resp, forgets a transaction whose strobe drops.
    initial begin
        int lat;
        bit busy;
        txn_t t;
        busy = 0;
        lat = 0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
            if (!(bus.pmem_read || bus.pmem_write)) busy = 0;
            else begin
                if (!busy) begin
                    busy = 1;
                    lat = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 4));
                    t.wr = bus.pmem_write;
                    t.addr = bus.pmem_addr;
                    t.wdata = bus.pmem_wdata;
                    t.lat = lat;
                    log_q.push_back(t);
                end
                lat--;
                if (lat == 0) begin
                    busy = 0;
                    if (bus.pmem_write) pm_lines[bus.pmem_addr[31:5]] = bus.pmem_wdata;
                    else bus.pmem_rdata = pm_get(bus.pmem_addr[31:5]);
                    bus.pmem_resp = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        assert (!(bus.dcache_read && bus.dcache_write)) else $error("illegal simultaneous read and write request");
        if (!rst) begin
            if (bus.pmem_read && bus.pmem_write) check(0, "pmem_exclusive", 2'b11, 2'b00);
            if (bus.dcache_resp) begin
                if (sb.size() == 0) check(0, "unexpected_resp", 1, 0);
                else begin
                    e = sb.pop_front();
                    if (e.rd) check(bus.dcache_rdata == e.data, "rdata", bus.dcache_rdata, e.data);
                end
            end
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic [26:0] la;
        int idx, w, stall, exp_stall;
        bit res, done;
        txn_t ex[$];
        exp_t e;
        logic [255:0] line;
        la = addr[31:5];
        idx = int'(la[3:0]);
        w = int'(addr[4:2]);
        res = s_valid[idx] && s_la[idx] == la;
        if (!res) begin
            m_misses++;
            if (s_dirty[idx]) ex.push_back('{1'b1, {s_la[idx], 5'b0}, ref_get(s_la[idx]), 0});
            ex.push_back('{1'b0, {la, 5'b0}, 256'b0, 0});
            s_la[idx] = la;
            s_valid[idx] = 1;
            s_dirty[idx] = 0;
        end
        m_hits++;
        line = ref_get(la);
        e.rd = !wr;
        e.data = line[w*32 +: 32];
        sb.push_back(e);
        if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) line[w*32 + b*8 +: 8] = wd[b*8 +: 8];
            ref_lines[la] = line;
            if (|be) s_dirty[idx] = 1;
        end
        bus.dcache_read = !wr;
        bus.dcache_write = wr;
        bus.dcache_addr = addr;
        bus.dcache_byte_enable = be;
        bus.dcache_wdata = wd;
        stall = 0;
        done = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (bus.dcache_resp) done = 1;
            else stall++;
        end
        @(posedge clk);
        #1;
        bus.dcache_read = 1'b0;
        bus.dcache_write = 1'b0;
        check(done, "resp_timeout", done, 1);
        exp_stall = res ? 0 : 1;
        foreach (log_q[i]) exp_stall += log_q[i].lat;
        check(stall == exp_stall, "stall_cycles", stall, exp_stall);
        check(log_q.size() == ex.size(), "txn_count", log_q.size(), ex.size());
        for (int i = 0; i < ex.size() && i < log_q.size(); i++) begin
            check(log_q[i].wr == ex[i].wr, "txn_kind", log_q[i].wr, ex[i].wr);
            check(log_q[i].addr == ex[i].addr, "pmem_addr", log_q[i].addr, ex[i].addr);
            if (ex[i].wr) check(log_q[i].wdata == ex[i].wdata, "pmem_wdata", log_q[i].wdata, ex[i].wdata);
        end
        log_q.delete();
    endtask

    task automatic check_perf();
`ifdef DCACHE_PERF_CNT_EN
        check(perf_hits == m_hits, "perf_hits", perf_hits, m_hits);
        check(perf_misses == m_misses, "perf_misses", perf_misses, m_misses);
`endif
    endtask

    initial begin
        logic [255:0] l;
        logic [31:0] a;
        bit saw;
        bus.dcache_read = 1'b0;
        bus.dcache_write = 1'b0;
        bus.dcache_addr = '0;
        bus.dcache_byte_enable = '0;
        bus.dcache_wdata = '0;
        fixed_lat = 0;
        checks = 0;
        errors = 0;
        m_hits = 0;
        m_misses = 0;
        l = init_line(27'h80);
        l[63:32] = 32'hDEAD_BEEF;
        pm_lines[27'h80] = l;
        ref_lines = pm_lines;
        repeat (3) @(posedge clk);
        #1;
        check(!bus.dcache_resp && !bus.pmem_read && !bus.pmem_write, "reset_outputs",
              {bus.dcache_resp, bus.pmem_read, bus.pmem_write}, 3'b000);
        rst = 1'b0;
        check_perf();

        fixed_lat = 3;
        do_req(0, 32'h0000_1004, 4'h0, 32'h0);
        do_req(1, 32'h0000_1004, 4'b0100, 32'h00AB_0000);
        do_req(0, 32'h0000_1004, 4'h0, 32'h0);
        do_req(0, 32'h0000_1204, 4'h0, 32'h0);
        do_req(1, 32'h0000_1204, 4'b0000, 32'hFFFF_FFFF);
        do_req(0, 32'h0000_1004, 4'h0, 32'h0);
        check_perf();

        fixed_lat = 4;
        a = 32'h7FE0_0048;
        bus.dcache_read = 1'b1;
        bus.dcache_addr = a;
        saw = 0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge clk);
            saw = bus.pmem_read;
        end
        check(saw, "fill_started", saw, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check(!bus.pmem_read && !bus.pmem_write, "rst_abandons_fill", {bus.pmem_read, bus.pmem_write}, 2'b00);
        rst = 1'b0;
        bus.dcache_read = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s_valid[i] = 0;
            s_dirty[i] = 0;
        end
        ref_lines = pm_lines;
        m_hits = 0;
        m_misses = 0;
        @(posedge clk);
        #1;
        sb.delete();
        log_q.delete();
        check_perf();
        do_req(0, a, 4'h0, 32'h0);

        fixed_lat = 0;
        for (int i = 0; i < 300; i++) begin
            a = 32'h1000 + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 15) << 5) + ($urandom_range(0, 7) << 2);
            do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
        check_perf();
        repeat (2) @(posedge clk);
        check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
